// File: rtl/bp_pkg.sv
// Shared definitions for the local-history branch predictor: opcode groups, clear FSM states, counter step.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package bp_pkg;

   // MIPS opcode field values used by branch decode
   localparam logic [5:0] REGIMM_INST = 6'b000001;
   localparam logic [3:0] BR_OP_GRP   = 4'b0001;  // beq/bne/blez/bgtz
   localparam logic [3:0] BRL_OP_GRP  = 4'b0101;  // beql/bnel/blezl/bgtzl
   localparam logic [3:0] RT_BR_GRP   = 4'b0000;  // bltz/bgez
   localparam logic [3:0] RT_BRL_GRP  = 4'b0001;  // bltzl/bgezl

   // Widest counter the shared step function handles
   localparam int CTR_MAX_W = 16;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } bp_state_e;

   // Saturating up/down step; ctr_max is the all-ones value of the real counter width
   function automatic logic [CTR_MAX_W-1:0] ctr_next(input logic [CTR_MAX_W-1:0] ctr,
                                                     input logic                 taken,
                                                     input logic [CTR_MAX_W-1:0] ctr_max);
      if (taken) begin
         return (ctr >= ctr_max) ? ctr_max : ctr + CTR_MAX_W'(1);
      end
      return (ctr == '0) ? '0 : ctr - CTR_MAX_W'(1);
   endfunction

endpackage

// File: rtl/bp_sat_table.sv
// Generic table with one synchronous write port and two asynchronous read ports.
// Latency: reads combinational; a write is visible from the cycle after its clock edge.
// Backpressure: none; a same-cycle read of the written entry returns the old contents.
module bp_sat_table #(
   parameter int ADDR_W = 4,
   parameter int WIDTH  = 2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [WIDTH-1:0]  wd,
   input  logic [ADDR_W-1:0] ra0,
   output logic [WIDTH-1:0]  rd0,
   input  logic [ADDR_W-1:0] ra1,
   output logic [WIDTH-1:0]  rd1
);

   localparam int DEPTH = 1 << ADDR_W;

   // Contents are initialised by the owner's clear sequence, so no reset here
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Single write port, clocked
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wa] <= wd;
      end
   end

   // Lookup port (fetch side) and update port (memory-stage side) read independently
   assign rd0 = mem_q[ra0];
   assign rd1 = mem_q[ra1];

endmodule

// File: rtl/branch_predict_lht.sv
// Two-level local-history direction predictor with post-reset table clear and perf counters.
// Latency: fetch lookup combinational, registered into decode (1 cycle); updates land on the next edge.
// Backpressure: stallD holds the decode prediction, flushD clears it (flush wins).
module branch_predict_lht
   import bp_pkg::*;
#(
   parameter int BHT_IDX_W = 10,
   parameter int HIST_W    = 6,
   parameter int PHT_IDX_W = 8,
   parameter int CTR_W     = 2,
   parameter bit HASH_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flushD,
   input  logic        stallD,
   input  logic [31:0] instrD,
   input  logic [31:0] pcF,
   input  logic [31:0] pcM,
   input  logic        branchM,
   input  logic        actual_takeM,
   input  logic        pred_takeM,
   output logic        branchD,
   output logic        branchL_D,
   output logic        pred_takeD,
   output logic        init_done,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispred_cnt
);

   // Clear pointer must sweep the larger of the two tables
   localparam int                   CLR_W       = (BHT_IDX_W > PHT_IDX_W) ? BHT_IDX_W : PHT_IDX_W;
   localparam logic [CLR_W-1:0]     CLR_LAST    = {CLR_W{1'b1}};
   localparam logic [CTR_W-1:0]     CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};
   localparam logic [CTR_MAX_W-1:0] CTR_SAT     = CTR_MAX_W'({CTR_W{1'b1}});

   bp_state_e          state_q, state_d;
   logic [CLR_W-1:0]   clr_ptr_q, clr_ptr_d;
   logic               pred_q, pred_d;
   logic [31:0]        branch_cnt_q, branch_cnt_d;
   logic [31:0]        mispred_cnt_q, mispred_cnt_d;

   logic [5:0]           op;
   logic [4:0]           rt;
   logic                 is_regimm;
   logic [HIST_W-1:0]    hist_f, hist_m;
   logic [PHT_IDX_W-1:0] pht_idx_f, pht_idx_m;
   logic [CTR_W-1:0]     ctr_f, ctr_m;
   logic                 pred_take_f;
   logic                 run, upd;
   logic                 bht_we, pht_we;
   logic [BHT_IDX_W-1:0] bht_wa;
   logic [PHT_IDX_W-1:0] pht_wa;
   logic [HIST_W-1:0]    bht_wd;
   logic [CTR_W-1:0]     pht_wd;
   logic                 unused_bits;

   // History (zero-extended) optionally folded with the word-aligned PC
   function automatic logic [PHT_IDX_W-1:0] pht_hash(input logic [HIST_W-1:0]    h,
                                                     input logic [PHT_IDX_W-1:0] pc_bits);
      logic [PHT_IDX_W-1:0] hz;
      hz = PHT_IDX_W'(h);
      return HASH_EN ? (hz ^ pc_bits) : hz;
   endfunction

   // Branch decode is purely on the instruction word
   assign op        = instrD[31:26];
   assign rt        = instrD[20:16];
   assign is_regimm = (op == REGIMM_INST);
   assign branchD   = (is_regimm && (rt[4:1] == RT_BR_GRP || rt[4:1] == RT_BRL_GRP))
                    || (op[5:2] == BR_OP_GRP) || (op[5:2] == BRL_OP_GRP);
   assign branchL_D = (is_regimm && rt[4:1] == RT_BRL_GRP) || (op[5:2] == BRL_OP_GRP);

   assign run       = (state_q == RUN);
   assign upd       = run & branchM;
   assign init_done = run;

   // Per-PC history table
   bp_sat_table #(.ADDR_W(BHT_IDX_W), .WIDTH(HIST_W)) u_bht (
      .clk (clk),
      .we  (bht_we),
      .wa  (bht_wa),
      .wd  (bht_wd),
      .ra0 (pcF[BHT_IDX_W+1:2]),
      .rd0 (hist_f),
      .ra1 (pcM[BHT_IDX_W+1:2]),
      .rd1 (hist_m)
   );

   // Pattern table of saturating counters
   bp_sat_table #(.ADDR_W(PHT_IDX_W), .WIDTH(CTR_W)) u_pht (
      .clk (clk),
      .we  (pht_we),
      .wa  (pht_wa),
      .wd  (pht_wd),
      .ra0 (pht_idx_f),
      .rd0 (ctr_f),
      .ra1 (pht_idx_m),
      .rd1 (ctr_m)
   );

   assign pht_idx_f   = pht_hash(hist_f, pcF[PHT_IDX_W+1:2]);
   assign pht_idx_m   = pht_hash(hist_m, pcM[PHT_IDX_W+1:2]);
   assign pred_take_f = ctr_f[CTR_W-1] & run;

   // Table write source: clear sweep while clearing, branch training once running
   always_comb begin
      bht_we = 1'b0;
      bht_wa = pcM[BHT_IDX_W+1:2];
      bht_wd = HIST_W'({hist_m, actual_takeM});
      pht_we = 1'b0;
      pht_wa = pht_idx_m;
      pht_wd = CTR_W'(ctr_next(CTR_MAX_W'(ctr_m), actual_takeM, CTR_SAT));
      if (state_q == CLEAR) begin
         // Smaller table stops writing once the pointer runs past its depth
         bht_we = ((clr_ptr_q >> BHT_IDX_W) == '0);
         bht_wa = clr_ptr_q[BHT_IDX_W-1:0];
         bht_wd = '0;
         pht_we = ((clr_ptr_q >> PHT_IDX_W) == '0);
         pht_wa = clr_ptr_q[PHT_IDX_W-1:0];
         pht_wd = CTR_WEAK_NT;
      end else if (branchM) begin
         bht_we = 1'b1;
         pht_we = 1'b1;
      end
   end

   // Clear FSM next state, decode prediction register and counters
   always_comb begin
      state_d       = state_q;
      clr_ptr_d     = clr_ptr_q;
      pred_d        = pred_q;
      branch_cnt_d  = branch_cnt_q + 32'(upd);
      mispred_cnt_d = mispred_cnt_q + 32'(upd & (pred_takeM ^ actual_takeM));
      if (state_q == CLEAR) begin
         clr_ptr_d = clr_ptr_q + CLR_W'(1);
         if (clr_ptr_q == CLR_LAST) begin
            state_d = RUN;
         end
      end
      if (flushD) begin
         pred_d = 1'b0;
      end else if (!stallD) begin
         pred_d = pred_take_f;
      end
   end

   // State registers; table contents are deliberately outside reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= CLEAR;
         clr_ptr_q     <= '0;
         pred_q        <= 1'b0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         clr_ptr_q     <= clr_ptr_d;
         pred_q        <= pred_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign pred_takeD  = branchD & pred_q;
   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

   // Instruction and PC bits that play no part in prediction
   assign unused_bits = ^{instrD[25:21], instrD[15:0], pcF[1:0], pcM[1:0],
                          pcF[31:CLR_W+2], pcM[31:CLR_W+2]};

endmodule
